// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: measurement FSM states and default counter sizing.
package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    FIRST = 2'd2,
    RUN   = 2'd3
  } meas_state_e;

  localparam int CW_DEF       = 8;
  localparam int LOCK_CNT_DEF = 4;
  localparam int MW_DEF       = 3;
  localparam int CNT_MAX      = 2**CW_DEF - 1;

  // Saturation value of a cw-bit period counter.
  function automatic int cnt_max(input int cw);
    return (1 << cw) - 1;
  endfunction

endpackage

// File: rtl/div_sync2.sv
// Two-flop synchronizer for the divided clock; both stages reset high so a
// high input at reset release never looks like a rising edge downstream.
module div_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/div_ratio_meter.sv
// Recovers period and high time of a divided clock in clk cycles, with lock
// and sticky overflow status. Define DIV_SYNC_EN to synchronize div_in first.
module div_ratio_meter
  import adpll_pkg::*;
#(
  parameter int CW       = CW_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int MW       = MW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          div_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          meas_valid,
  output logic          locked,
  output logic          overflow,
  output logic [1:0]    dbg_state
);

  localparam logic [CW-1:0] CNT_LAST = CW'(cnt_max(CW) - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [MW-1:0] LOCK_M   = MW'(LOCK_CNT);

  logic div_s;

`ifdef DIV_SYNC_EN
  div_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (div_in),
    .q_o   (div_s)
  );
`else
  assign div_s = div_in;
`endif

  meas_state_e   state_q, state_d;
  logic          div_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] ref_q, ref_d;
  logic [MW-1:0] match_q, match_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] high_q, high_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;
  logic          ovf_q, ovf_d;
  logic          rise;

  assign rise = div_s & ~div_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= 1'b1;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      ref_q    <= '0;
      match_q  <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_s;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      ref_q    <= ref_d;
      match_q  <= match_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    ref_d    = ref_q;
    match_d  = match_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    ovf_d    = ovf_q;

    // Dropping en abandons any partial period and clears status.
    if (!en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      hcnt_d   = '0;
      match_d  = '0;
      locked_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = SEEK;
        SEEK: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
            state_d = FIRST;
          end
        end
        FIRST, RUN: begin
          if (rise) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            valid_d  = 1'b1;
            cnt_d    = CNT_ONE;
            hcnt_d   = CNT_ONE;
            if (state_q == FIRST) begin
              state_d = RUN;
              ref_d   = cnt_q;
              match_d = '0;
            end else if (cnt_q == ref_q) begin
              if (match_q != LOCK_M) match_d = match_q + 1'b1;
              locked_d = (match_d == LOCK_M);
            end else begin
              ref_d    = cnt_q;
              match_d  = '0;
              locked_d = 1'b0;
            end
          end else if (cnt_q == CNT_LAST) begin
            // Counter would saturate: period too long to measure, re-seek.
            ovf_d    = 1'b1;
            locked_d = 1'b0;
            match_d  = '0;
            cnt_d    = '0;
            hcnt_d   = '0;
            state_d  = SEEK;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            hcnt_d = hcnt_q + {{(CW-1){1'b0}}, div_s};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign locked     = locked_q;
  assign overflow   = ovf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_div_ratio_meter.sv
// Directed and randomized bench for div_ratio_meter against a sample-window model.
module tb_div_ratio_meter;
  import adpll_pkg::*;

  localparam int CW       = 4;
  localparam int LOCK_CNT = 4;
  localparam int MW       = 3;
  localparam int CNT_TOP  = (1 << CW) - 1;
`ifdef DIV_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic en;
  logic div_in;
  always #5 clk = ~clk;

  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          locked;
  logic          overflow;
  logic [1:0]    dbg_state;

  div_ratio_meter #(.CW(CW), .LOCK_CNT(LOCK_CNT), .MW(MW)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .div_in     (div_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // reference model: window of samples since the last accepted rising edge
  bit  m_prev;
  bit  m_armed;
  bit  m_started;
  int  win[$];
  int  hist[$];
  bit  sdly[$];
  int  e_period, e_high;
  bit  e_valid, e_locked, e_ovf;
  logic [2*CW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b1;
    m_armed = 1'b0;
    m_started = 1'b0;
    win.delete();
    hist.delete();
    sdly.delete();
    for (int i = 0; i < LAT; i++) sdly.push_back(1'b1);
    e_period = 0;
    e_high = 0;
    e_valid = 1'b0;
    e_locked = 1'b0;
    e_ovf = 1'b0;
    exp_q.delete();
  endtask

  function automatic bit lock_check();
    int n = hist.size();
    if (n < LOCK_CNT + 1) return 1'b0;
    for (int i = n - LOCK_CNT - 1; i < n; i++)
      if (hist[i] != hist[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit d, input bit e);
    bit s, r;
    sdly.push_back(d);
    s = sdly.pop_front();
    r = s && !m_prev;
    m_prev = s;
    e_valid = 1'b0;
    if (!e) begin
      m_armed = 1'b0;
      m_started = 1'b0;
      win.delete();
      hist.delete();
      e_ovf = 1'b0;
      e_locked = 1'b0;
      return;
    end
    if (!m_armed) begin
      m_armed = 1'b1;
      return;
    end
    if (m_started) begin
      if (r) begin
        e_period = win.size();
        e_high = win.sum();
        e_valid = 1'b1;
        exp_q.push_back({CW'(e_period), CW'(e_high)});
        hist.push_back(e_period);
        win.delete();
        win.push_back(1);
        e_locked = lock_check();
      end else if (win.size() + 1 == CNT_TOP) begin
        e_ovf = 1'b1;
        e_locked = 1'b0;
        m_started = 1'b0;
        hist.delete();
        win.delete();
      end else begin
        win.push_back(int'(s));
      end
    end else if (r) begin
      m_started = 1'b1;
      win.delete();
      win.push_back(1);
    end
  endtask

  // driver: apply one sample at negedge, check 1 time unit after posedge
  task automatic step(input bit d, input bit e);
    logic [31:0] want;
    div_in = d;
    en = e;
    @(posedge clk);
    model_step(d, e);
    #1;
    check("meas_valid", meas_valid, e_valid);
    check("locked", locked, e_locked);
    check("overflow", overflow, e_ovf);
    check("period", period, e_period);
    check("high_time", high_time, e_high);
    if (meas_valid === 1'b1) begin
      want = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
      check("sb_report", {period, high_time}, want);
    end
    @(negedge clk);
  endtask

  task automatic pat(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < hi + lo; i++) step(i < hi, 1'b1);
  endtask

  initial begin
    int p, h;
    bit drop;
    reset = 1'b1;
    en = 1'b0;
    div_in = 1'b0;
    model_reset();
    #3;
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_ovf", overflow, 0);
    check("rst_state", dbg_state, 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // ratio 4, 50% duty
    pat(2, 2, 10);
    check("p4_period", period, 4);
    check("p4_high", high_time, 2);
    check("p4_locked", locked, 1);

    // switch to ratio 6: lock drops, then returns
    pat(3, 3, 8);
    check("p6_period", period, 6);
    check("p6_high", high_time, 3);
    check("p6_locked", locked, 1);

    // ratio 3, one-sample high
    pat(1, 2, 8);
    check("p3_period", period, 3);
    check("p3_high", high_time, 1);
    check("p3_locked", locked, 1);

    // stuck low after one rise -> overflow
    step(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    check("ovf_set", overflow, 1);
    check("ovf_unlock", locked, 0);
    pat(2, 2, 6);
    check("ovf_sticky", overflow, 1);
    check("ovf_resume_period", period, 4);

    // en dropped mid-period
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("en_ovf_clr", overflow, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    pat(2, 3, 5);
    check("en_resume_period", period, 5);

    // randomized periods, occasional overflow and en glitch
    for (int n = 0; n < 150; n++) begin
      p = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 20) : $urandom_range(2, 14);
      h = $urandom_range(1, p - 1);
      drop = ($urandom_range(0, 14) == 0);
      for (int i = 0; i < p; i++) step(i < h, !(drop && i == p / 2));
    end

    // async reset mid-run with div_in high
    pat(2, 2, 6);
    div_in = 1'b1;
    step(1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("arst_period", period, 0);
    check("arst_high", high_time, 0);
    check("arst_valid", meas_valid, 0);
    check("arst_locked", locked, 0);
    check("arst_ovf", overflow, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    pat(2, 2, 4);
    check("arst_resume_period", period, 4);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 1'b0);
    check("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
